uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and baud divisor helper.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                               input int unsigned baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of an oversampled line, bytes out on valid/ready.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned clk_freq_hz = 50_000_000,
  parameter int unsigned baud_rate   = 57600
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_uart_rx,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_frame_err,
  output logic                      o_overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(clk_freq_hz, baud_rate);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned IDX_W        = $clog2(UART_DATA_BITS);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  uart_rx_state_t            state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic                      valid_n, ferr_n, ovr_n;
  logic                      rx_s, rx_d;
  logic [1:0]                live;
  logic                      armed, armed_n;
  logic                      tick;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_uart_rx),
    .q     (rx_s)
  );

  assign tick = (cnt == '0);

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rx_d        <= 1'b1;
      live        <= '0;
      armed       <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      rx_d        <= rx_s;
      live        <= {live[0], 1'b1};
      armed       <= armed_n;
      o_data      <= data_n;
      o_valid     <= valid_n;
      o_frame_err <= ferr_n;
      o_overrun   <= ovr_n;
    end
  end

  // Start detection is armed only once the synchronized line has been seen high,
  // so a line that is low after reset or after a frame error cannot start a frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = o_data;
    valid_n = o_valid & ~i_ready;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    armed_n = armed | (live[1] & rx_s);

    case (state)
      IDLE: begin
        if (armed && rx_d && !rx_s) begin
          state_n = START;
          cnt_n   = CNT_W'(HALF_BIT - 1);
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (rx_s) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
          idx_n   = '0;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          shreg_n = {rx_s, shreg[UART_DATA_BITS-1:1]};
          cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
          idx_n   = idx + IDX_W'(1);
          if (idx == IDX_W'(UART_DATA_BITS - 1)) state_n = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = IDLE;
          if (!rx_s) begin
            ferr_n  = 1'b1;
            armed_n = 1'b0;
          end else if (!o_valid || i_ready) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end else begin
            ovr_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       line  = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovr;

  int n_cmp = 0, n_fail = 0;
  int n_ferr = 0, n_ovr = 0, n_acc = 0;
  int cyc = 0, rise_cyc = 0, start_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(
    .clk_freq_hz (1_000_000),
    .baud_rate   (100_000)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_uart_rx   (line),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (ferr),
    .o_overrun   (ovr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses, pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (ferr === 1'b1) n_ferr++;
    if (ovr === 1'b1) n_ovr++;
    if (valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = valid;
    if (valid === 1'b1 && ready === 1'b1) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rx_byte: got %02h, expected no byte", data);
      end else begin
        check("rx_byte", 32'(data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called aligned 1 time unit after a rising edge; stays aligned on return.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    line = 1'b0;
    idle(10);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      idle(10);
    end
    line = stop;
    idle(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle(3);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    check("reset_ovr", 32'(ovr), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single byte, latency from start edge to o_valid.
    ready = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(20);
    check("t1_latency", 32'(rise_cyc - start_cyc), 32'd98);
    check("t1_ferr", 32'(n_ferr), 32'd0);
    check("t1_valid_low", 32'(valid), 32'd0);

    // Back-to-back frames.
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hFF);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    check("t2_accepts", 32'(n_acc), 32'd4);
    check("t2_ferr", 32'(n_ferr), 32'd0);
    check("t2_ovr", 32'(n_ovr), 32'd0);

    // Short low glitch must be rejected.
    line = 1'b0;
    idle(3);
    line = 1'b1;
    idle(30);
    check("t3_glitch_acc", 32'(n_acc), 32'd4);
    check("t3_glitch_ferr", 32'(n_ferr), 32'd0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle(20);
    check("t3_accepts", 32'(n_acc), 32'd5);

    // Bad stop bit followed by a long break.
    send_byte(8'h3C, 1'b0);
    idle(500);
    check("t4_ferr_once", 32'(n_ferr), 32'd1);
    check("t4_valid_low", 32'(valid), 32'd0);
    line = 1'b1;
    idle(30);
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1);
    idle(20);
    check("t4_ferr_after", 32'(n_ferr), 32'd1);
    check("t4_accepts", 32'(n_acc), 32'd6);

    // Overrun: second byte dropped while the first is held.
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(20);
    check("t5_valid_held", 32'(valid), 32'd1);
    check("t5_data_held", 32'(data), 32'h11);
    check("t5_overrun", 32'(n_ovr), 32'd1);
    ready = 1'b1;
    idle(3);
    check("t5_valid_drop", 32'(valid), 32'd0);
    check("t5_accepts", 32'(n_acc), 32'd7);

    // Asynchronous reset in the middle of a frame, released while the line is low.
    fork
      send_byte(8'h77, 1'b1);
      begin
        repeat (45) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_data", 32'(data), 32'd0);
        check("t6_rst_ferr", 32'(ferr), 32'd0);
        check("t6_rst_ovr", 32'(ovr), 32'd0);
        repeat (38) @(posedge clk);
        #3;
        rst_n = 1'b1;
      end
    join
    idle(20);
    check("t6_no_residue_acc", 32'(n_acc), 32'd7);
    check("t6_no_residue_ferr", 32'(n_ferr), 32'd1);
    exp_q.push_back(8'h99);
    send_byte(8'h99, 1'b1);
    idle(20);
    check("t6_accepts", 32'(n_acc), 32'd8);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
